// File: rtl/risk_5_mc.sv
// risk_5_mc: multi-cycle core (custom 32-bit ISA, sync imem, valid/ready switch input, HALT).
// Define RISK5_DBG_PORT_EN to add a combinational debug read port (dbg_ra/dbg_rd).
module risk_5_mc #(
   parameter int XLEN = 32,
   parameter int PC_W = 10,
   parameter int SW_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic [SW_W-1:0] sw,
   input  logic            sw_valid,
   output logic            sw_ready,
   output logic            retire,
   output logic            halted
`ifdef RISK5_DBG_PORT_EN
   ,
   input  logic [4:0]      dbg_ra,
   output logic [XLEN-1:0] dbg_rd
`endif
);
   localparam int SH = $clog2(XLEN);
   typedef enum logic [1:0] {FETCH, EXEC, WAIT_IN, HALT} state_t;
   state_t state, state_nx;
   logic [PC_W-1:0] pc, imm_pc;
   logic [31:0] ir, inst;
   logic [XLEN-1:0] rf [32];
   logic [XLEN-1:0] op1, op2, alu, imm_x, wdata;
   logic [SH-1:0] shamt;
   logic flag, wen, adv;
   logic b, c, we;
   logic [1:0] ws;
   logic [3:0] op;
   logic [4:0] ra1, ra2, wa;
   logic [7:0] imm;
   // The instruction word is only valid on the EXEC cycle; WAIT_IN works from the latched copy.
   assign inst = (state == WAIT_IN) ? ir : imem_rdata;
   assign {b, c, we, ws, op, ra1, ra2, wa, imm} = inst;
   assign imm_x = XLEN'($signed(imm));
   assign imm_pc = PC_W'($signed(imm));
   assign op1 = rf[ra1];
   assign op2 = rf[ra2];
   assign shamt = op2[SH-1:0];
   assign imem_addr = pc;
   assign halted = (state == HALT);
   assign wen = adv & we & (wa != 5'd0);
   assign wdata = (ws == 2'b00) ? imm_x : (ws == 2'b10) ? alu : XLEN'(sw);
   always_comb begin
      flag = 1'b0;
      alu = '0;
      case (op)
         4'h1: alu = op1 << shamt;
         4'h2: flag = $signed(op1) < $signed(op2);
         4'h3: flag = op1 < op2;
         4'h4: alu = op1 ^ op2;
         4'h5: alu = op1 >> shamt;
         4'h6: alu = op1 | op2;
         4'h7: alu = op1 & op2;
         4'h8: alu = op1 - op2;
         4'h9: flag = op1 == op2;
         4'hA: flag = op1 != op2;
         4'hB: flag = $signed(op1) >= $signed(op2);
         4'hC: flag = op1 >= op2;
         4'hD: alu = $signed(op1) >>> shamt;
         default: alu = op1 + op2;
      endcase
      alu = alu | XLEN'(flag);
   end
   always_comb begin
      state_nx = state;
      adv = 1'b0;
      retire = 1'b0;
      sw_ready = 1'b0;
      case (state)
         FETCH: state_nx = EXEC;
         EXEC: begin
            retire = !(ws == 2'b01 && we);
            adv = retire && ws != 2'b11;
            state_nx = (ws == 2'b11) ? HALT : retire ? FETCH : WAIT_IN;
         end
         WAIT_IN: begin
            sw_ready = 1'b1;
            adv = sw_valid;
            retire = sw_valid;
            state_nx = sw_valid ? FETCH : WAIT_IN;
         end
         default: state_nx = HALT;
      endcase
      retire = retire & ~rst;
      sw_ready = sw_ready & ~rst;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= '0;
         ir <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         if (state == EXEC) ir <= imem_rdata;
         if (adv) pc <= (b | (c & flag)) ? pc + imm_pc : pc + PC_W'(1);
         if (wen) rf[wa] <= wdata;
      end
   end
`ifdef RISK5_DBG_PORT_EN
   assign dbg_rd = (dbg_ra == 5'd0) ? '0 : rf[dbg_ra];
`endif
endmodule

// File: tb/tb_risk_5_mc.sv
// tb_risk_5_mc: directed programs for risk_5_mc (PC_W=4); register contents observed through branches.
module tb_risk_5_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic [7:0] sw = '0;
   logic sw_valid = 1'b0;
   logic sw_ready, retire, halted;
   logic [31:0] mem [16];
   int checks = 0, errors = 0, pulses, ready_cnt;
   risk_5_mc #(.XLEN(32), .PC_W(4), .SW_W(8)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .sw(sw), .sw_valid(sw_valid), .sw_ready(sw_ready), .retire(retire), .halted(halted)
   );
   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= mem[imem_addr];
   function automatic logic [31:0] ins(input logic b, c, we, input logic [1:0] ws, input logic [3:0] op,
                                       input logic [4:0] ra1, ra2, wa, input logic [7:0] imm);
      return {b, c, we, ws, op, ra1, ra2, wa, imm};
   endfunction
   function automatic logic [31:0] li(input logic [4:0] wa, input logic [7:0] imm);
      return ins(0, 0, 1, 2'b00, 4'h0, 5'd0, 5'd0, wa, imm);
   endfunction
   function automatic logic [31:0] alu(input logic [3:0] op, input logic [4:0] wa, ra1, ra2);
      return ins(0, 0, 1, 2'b10, op, ra1, ra2, wa, 8'h00);
   endfunction
   function automatic logic [31:0] br(input logic [3:0] op, input logic [4:0] ra1, ra2, input logic [7:0] imm);
      return ins(0, 1, 0, 2'b10, op, ra1, ra2, 5'd0, imm);
   endfunction
   localparam logic [31:0] HLT = {3'b000, 2'b11, 27'd0};
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic clear_mem;
      for (int i = 0; i < 16; i++) mem[i] = HLT;
   endtask
   task automatic do_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic step(input string tag, input int npc);
      @(negedge clk);
      chk({tag, " retire"}, {31'd0, retire}, 1);
      @(negedge clk);
      chk({tag, " next pc"}, {28'd0, imem_addr}, npc);
      chk({tag, " idle ready"}, {31'd0, sw_ready}, 0);
   endtask
   initial begin
      // Program A: immediates, ALU ops, taken compares, PC wrap
      clear_mem();
      mem[0] = li(1, 8'd5);
      mem[1] = li(2, 8'hFD);
      mem[2] = alu(4'h0, 3, 1, 2);
      mem[3] = li(5, 8'd2);
      mem[4] = br(4'h9, 3, 5, 8'd2);
      mem[6] = alu(4'h8, 6, 1, 2);
      mem[7] = li(7, 8'd8);
      mem[8] = br(4'h9, 6, 7, 8'd2);
      mem[10] = li(8, 8'd1);
      mem[11] = alu(4'hD, 9, 2, 8);
      mem[12] = li(10, 8'hFE);
      mem[13] = br(4'h9, 9, 10, 8'd2);
      mem[15] = ins(1, 0, 0, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 8'h01);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst imem_addr", {28'd0, imem_addr}, 0);
      chk("rst halted", {31'd0, halted}, 0);
      chk("rst sw_ready", {31'd0, sw_ready}, 0);
      chk("rst retire", {31'd0, retire}, 0);
      rst = 1'b0;
      chk("first fetch", {28'd0, imem_addr}, 0);
      step("li x1", 1);
      step("li x2", 2);
      step("add", 3);
      step("li x5", 4);
      step("x3==2", 6);
      step("sub", 7);
      step("li x7", 8);
      step("x6==8", 10);
      step("li x8", 11);
      step("sra", 12);
      step("li x10", 13);
      step("x9==fffffffe", 15);
      step("wrap", 0);
      // Program B: x0 write dropped, backward taken EQ, not-taken NE
      clear_mem();
      mem[0] = li(0, 8'd9);
      mem[1] = li(1, 8'd7);
      mem[2] = li(2, 8'd7);
      mem[3] = br(4'hA, 0, 3, 8'd2);
      mem[4] = br(4'h9, 1, 2, 8'hFE);
      do_reset();
      step("li x0", 1);
      step("li x1=7", 2);
      step("li x2=7", 3);
      step("x0 reads 0", 4);
      step("eq taken back", 2);
      mem[4] = br(4'hA, 1, 2, 8'hFE);
      step("li x2 again", 3);
      step("x0 again", 4);
      step("ne not taken", 5);
      // Program C: switch handshake with delayed valid, then HALT
      clear_mem();
      mem[0] = ins(0, 0, 1, 2'b01, 4'h0, 5'd0, 5'd0, 5'd4, 8'h00);
      mem[1] = li(5, 8'h52);
      mem[2] = li(6, 8'h53);
      mem[3] = alu(4'h0, 7, 5, 6);
      mem[4] = br(4'h9, 4, 7, 8'd2);
      do_reset();
      sw = 8'hA5;
      @(negedge clk);
      chk("in exec retire", {31'd0, retire}, 0);
      chk("in exec ready", {31'd0, sw_ready}, 0);
      pulses = 0;
      ready_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ready_cnt += int'(sw_ready);
         pulses += int'(retire);
      end
      @(negedge clk);
      sw_valid = 1'b1;
      #1;
      ready_cnt += int'(sw_ready);
      pulses += int'(retire);
      chk("transfer retire", {31'd0, retire}, 1);
      @(negedge clk);
      sw_valid = 1'b0;
      chk("ready cycles", ready_cnt, 6);
      chk("single retire", pulses, 1);
      chk("after in pc", {28'd0, imem_addr}, 1);
      chk("after in ready", {31'd0, sw_ready}, 0);
      step("li x5", 2);
      step("li x6", 3);
      step("x7=a5", 4);
      step("x4==a5", 6);
      @(negedge clk);
      chk("halt exec retire", {31'd0, retire}, 1);
      @(negedge clk);
      chk("halt c", {31'd0, halted}, 1);
      // Reset while waiting for switches: transfer is abandoned
      do_reset();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("wait ready", {31'd0, sw_ready}, 1);
      rst = 1'b1;
      sw_valid = 1'b1;
      #1;
      chk("rst wait ready", {31'd0, sw_ready}, 0);
      chk("rst wait retire", {31'd0, retire}, 0);
      clear_mem();
      mem[0] = br(4'hA, 4, 0, 8'd2);
      mem[1] = li(1, 8'd1);
      mem[2] = li(2, 8'd2);
      do_reset();
      sw_valid = 1'b0;
      chk("rst wait pc", {28'd0, imem_addr}, 0);
      step("x4 still 0", 1);
      step("li x1", 2);
      step("li x2", 3);
      @(negedge clk);
      chk("halt retire", {31'd0, retire}, 1);
      chk("halt not yet", {31'd0, halted}, 0);
      @(negedge clk);
      chk("halted", {31'd0, halted}, 1);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         pulses += int'(retire);
      end
      chk("halt no retire", pulses, 0);
      chk("halt pc frozen", {28'd0, imem_addr}, 3);
      chk("halt stays", {31'd0, halted}, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
